// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - 3-stage pipelined IEEE-754-style multiplier, round-to-nearest-even
// Stages: decode/classify, mantissa product, normalise/round/pack; valid/ready with stall-all back-pressure.
module fp_mult_pipe #(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] operand_a,
   input  logic [W-1:0] operand_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         flag_overflow,
   output logic         flag_underflow,
   output logic         flag_invalid
);

   localparam int EW = EXP_W + 2;
   localparam int MW = MAN_W + 1;
   localparam int PW = 2 * MW;

   localparam logic [EXP_W-1:0]        EXP_ONES = {EXP_W{1'b1}};
   localparam logic signed [EW-1:0]    BIAS     = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0]    E_MAX    = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0]    E_ZERO   = '0;
   localparam logic [W-1:0]            QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   logic advance;

   logic                 sa, sb;
   logic [EXP_W-1:0]     ea, eb;
   logic [MAN_W-1:0]     fa, fb;
   logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic                 sign_d, inv_d, inf_d, zero_d;
   logic signed [EW-1:0] exp_d;

   logic                 s1_valid_q, s1_sign_q, s1_inv_q, s1_inf_q, s1_zero_q;
   logic signed [EW-1:0] s1_exp_q;
   logic [MW-1:0]        s1_ma_q, s1_mb_q;

   logic [PW-1:0]        prod_d;
   logic                 s2_valid_q, s2_sign_q, s2_inv_q, s2_inf_q, s2_zero_q;
   logic signed [EW-1:0] s2_exp_q;
   logic [PW-1:0]        s2_prod_q;

   logic [PW-2:0]        norm;
   logic [MAN_W-1:0]     frac;
   logic                 guard, sticky, round_up;
   logic [MAN_W:0]       frac_rnd;
   logic signed [EW-1:0] exp_fin;

   logic [W-1:0]         result_d;
   logic                 ovf_d, unf_d, invf_d;
   logic                 out_valid_q, ovf_q, unf_q, invf_q;
   logic [W-1:0]         result_q;

   assign advance  = !out_valid_q || out_ready;
   assign in_ready = advance;

   assign {sa, ea, fa} = operand_a;
   assign {sb, eb, fb} = operand_b;

   // Subnormal inputs collapse to zero: only the exponent field is inspected.
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (ea == EXP_ONES) && (fa == '0);
   assign b_inf  = (eb == EXP_ONES) && (fb == '0);
   assign a_nan  = (ea == EXP_ONES) && (fa != '0);
   assign b_nan  = (eb == EXP_ONES) && (fb != '0);

   assign sign_d = sa ^ sb;
   assign inv_d  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
   assign inf_d  = a_inf || b_inf;
   assign zero_d = a_zero || b_zero;
   assign exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

   assign prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);

   // The product of two [1,2) mantissas lies in [1,4); drop the leading one after aligning.
   assign norm     = s2_prod_q[PW-1] ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
   assign frac     = norm[PW-2 -: MAN_W];
   assign guard    = norm[MAN_W];
   assign sticky   = |norm[MAN_W-1:0];
   assign round_up = guard && (sticky || frac[0]);
   assign frac_rnd = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
   assign exp_fin  = s2_exp_q + $signed({{(EW-1){1'b0}}, s2_prod_q[PW-1]})
                              + $signed({{(EW-1){1'b0}}, frac_rnd[MAN_W]});

   always_comb begin
      result_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      invf_d   = 1'b0;
      if (s2_valid_q) begin
         if (s2_inv_q) begin
            result_d = QNAN;
            invf_d   = 1'b1;
         end else if (s2_inf_q) begin
            result_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
         end else if (s2_zero_q) begin
            result_d = {s2_sign_q, {(W-1){1'b0}}};
         end else if (exp_fin >= E_MAX) begin
            result_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            ovf_d    = 1'b1;
         end else if (exp_fin <= E_ZERO) begin
            result_d = {s2_sign_q, {(W-1){1'b0}}};
            unf_d    = 1'b1;
         end else begin
            result_d = {s2_sign_q, exp_fin[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         invf_q      <= 1'b0;
      end else if (advance) begin
         s1_valid_q  <= in_valid;
         s1_sign_q   <= sign_d;
         s1_inv_q    <= inv_d;
         s1_inf_q    <= inf_d;
         s1_zero_q   <= zero_d;
         s1_exp_q    <= exp_d;
         s1_ma_q     <= {1'b1, fa};
         s1_mb_q     <= {1'b1, fb};

         s2_valid_q  <= s1_valid_q;
         s2_sign_q   <= s1_sign_q;
         s2_inv_q    <= s1_inv_q;
         s2_inf_q    <= s1_inf_q;
         s2_zero_q   <= s1_zero_q;
         s2_exp_q    <= s1_exp_q;
         s2_prod_q   <= prod_d;

         out_valid_q <= s2_valid_q;
         result_q    <= result_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         invf_q      <= invf_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign result         = result_q;
   assign flag_overflow  = ovf_q;
   assign flag_underflow = unf_q;
   assign flag_invalid   = invf_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb/tb_fp_mult_pipe.sv - directed-vector bench for fp_mult_pipe (single and double precision)
module tb_fp_mult_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        flag_overflow, flag_underflow, flag_invalid;

   logic        d_in_valid = 1'b0;
   logic        d_in_ready;
   logic [63:0] d_operand_a = '0;
   logic [63:0] d_operand_b = '0;
   logic        d_out_valid;
   logic        d_out_ready = 1'b1;
   logic [63:0] d_result;
   logic        d_flag_overflow, d_flag_underflow, d_flag_invalid;

   always #5 clk = ~clk;

   fp_mult_pipe dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .operand_a(operand_a), .operand_b(operand_b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .flag_overflow(flag_overflow), .flag_underflow(flag_underflow), .flag_invalid(flag_invalid)
   );

   fp_mult_pipe #(.EXP_W(11), .MAN_W(52)) dut_dp (
      .clk(clk), .rst(rst),
      .in_valid(d_in_valid), .in_ready(d_in_ready),
      .operand_a(d_operand_a), .operand_b(d_operand_b),
      .out_valid(d_out_valid), .out_ready(d_out_ready), .result(d_result),
      .flag_overflow(d_flag_overflow), .flag_underflow(d_flag_underflow), .flag_invalid(d_flag_invalid)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [2:0]  f;   // {overflow, underflow, invalid}
   } vec_t;

   typedef struct packed {
      logic [31:0] r;
      logic [2:0]  f;
   } exp_t;

   vec_t vecs [16];
   exp_t exp_q [$];
   exp_t e;

   int n_tests = 0;
   int n_fail  = 0;
   int n_out   = 0;
   int n_stall = 0;
   logic        stall_prev = 1'b0;
   logic [31:0] held_res;
   logic [2:0]  held_fl;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   // Output scoreboard: every accepted result is matched in order against pushed expectations.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_result", result, held_res);
            check("hold_flags", {flag_overflow, flag_underflow, flag_invalid}, held_fl);
         end
         if (out_valid && !out_ready) begin
            check("in_ready_stall", in_ready, 0);
            n_stall++;
            stall_prev = 1'b1;
            held_res   = result;
            held_fl    = {flag_overflow, flag_underflow, flag_invalid};
         end else begin
            stall_prev = 1'b0;
         end
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               check("unexpected_out", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check("result", result, e.r);
               check("flags", {flag_overflow, flag_underflow, flag_invalid}, e.f);
            end
         end
      end
   end

   task automatic push_exp(input int i);
      exp_q.push_back({vecs[i].r, vecs[i].f});
   endtask

   task automatic single(input int i);
      int lat;
      @(posedge clk); #1;
      check($sformatf("in_ready_idle_%0d", i), in_ready, 1);
      in_valid  = 1'b1;
      operand_a = vecs[i].a;
      operand_b = vecs[i].b;
      push_exp(i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 8);
      check($sformatf("latency_%0d", i), lat, 3);
      @(posedge clk); #1;
   endtask

   task automatic stream_bp();
      int   idx = 0;
      int   c = 0;
      int   base_out = n_out;
      int   base_stall = n_stall;
      logic took;
      @(posedge clk); #1;
      while (idx < 6 && c < 40) begin
         out_ready = !(c >= 4 && c <= 7);
         in_valid  = 1'b1;
         operand_a = vecs[idx].a;
         operand_b = vecs[idx].b;
         #1;
         took = in_ready;
         if (took) push_exp(idx);
         @(posedge clk); #1;
         if (took) idx++;
         c++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(posedge clk);
      #1;
      check("bp_drained", exp_q.size(), 0);
      check("bp_count", n_out - base_out, 6);
      check("bp_stall_cycles", n_stall - base_stall, 4);
   endtask

   task automatic full_rate();
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               check($sformatf("full_rate_in_ready_%0d", i), in_ready, 1);
               in_valid  = 1'b1;
               operand_a = vecs[i].a;
               operand_b = vecs[i].b;
               push_exp(i);
               @(posedge clk); #1;
            end
            in_valid = 1'b0;
         end
         begin
            int k = 0;
            int run = 0;
            while (!out_valid && k < 20) begin
               @(negedge clk);
               k++;
            end
            while (out_valid && run < 20) begin
               run++;
               @(negedge clk);
            end
            check("full_rate_run", run, 8);
         end
      join
      @(posedge clk); #1;
      check("full_rate_drained", exp_q.size(), 0);
   endtask

   task automatic reset_flight();
      @(posedge clk); #1;
      in_valid  = 1'b1;
      operand_a = vecs[0].a;
      operand_b = vecs[0].b;
      @(posedge clk); #1;
      operand_a = vecs[1].a;
      operand_b = vecs[1].b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_result", result, 0);
      check("rst_flags", {flag_overflow, flag_underflow, flag_invalid}, 0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("rst_no_stale_%0d", k), out_valid, 0);
      end
   endtask

   task automatic dp_test();
      int lat;
      @(posedge clk); #1;
      check("dp_in_ready", d_in_ready, 1);
      d_in_valid  = 1'b1;
      d_operand_a = 64'h3FF8000000000000;
      d_operand_b = 64'h4000000000000000;
      @(posedge clk); #1;
      d_in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!d_out_valid && lat < 8);
      check("dp_latency", lat, 3);
      check("dp_result", d_result, 64'h4008000000000000);
      check("dp_flags", {d_flag_overflow, d_flag_underflow, d_flag_invalid}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000};
      vecs[1]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000};
      vecs[2]  = '{32'hBF800000, 32'h40000000, 32'hC0000000, 3'b000};
      vecs[3]  = '{32'h3FC00000, 32'h3F800001, 32'h3FC00002, 3'b000};
      vecs[4]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000};
      vecs[5]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 3'b100};
      vecs[6]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 3'b010};
      vecs[7]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 3'b000};
      vecs[8]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001};
      vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000};
      vecs[10] = '{32'h7FC12345, 32'h3F800000, 32'h7FC00000, 3'b001};
      vecs[11] = '{32'h80000000, 32'h3F800000, 32'h80000000, 3'b000};
      vecs[12] = '{32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 3'b000};
      vecs[13] = '{32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 3'b000};
      vecs[14] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 3'b000};
      vecs[15] = '{32'h00800000, 32'h3F800000, 32'h00800000, 3'b000};

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_result", result, 0);
      check("reset_flags", {flag_overflow, flag_underflow, flag_invalid}, 0);
      check("reset_dp_out_valid", d_out_valid, 0);

      for (int i = 0; i < 16; i++) single(i);
      stream_bp();
      full_rate();
      reset_flight();
      dp_test();

      @(posedge clk); #1;
      check("final_queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
